// File: rtl/loop_nest_sequencer_pkg.sv
// Shared accelerator definitions: sequencer FSM states and default geometry.
package loop_nest_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefStep  = 4;

endpackage

// File: rtl/loop_nest_sequencer_if.sv
// Index-tuple stream from the loop-nest sequencer to its consumer.
interface loop_nest_sequencer_if
    import loop_nest_sequencer_pkg::*;
#(
    parameter int unsigned Width = DefWidth
);
    logic             idx_valid_o;
    logic             idx_ready_i;
    logic [Width-1:0] m_idx_o;
    logic [Width-1:0] k_idx_o;
    logic [Width-1:0] n_idx_o;
    logic             first_k_o;
    logic             last_k_o;
    logic             last_o;

    modport master (
        output idx_valid_o, m_idx_o, k_idx_o, n_idx_o, first_k_o, last_k_o, last_o,
        input  idx_ready_i
    );

    modport slave (
        input  idx_valid_o, m_idx_o, k_idx_o, n_idx_o, first_k_o, last_k_o, last_o,
        output idx_ready_i
    );
endinterface

// File: rtl/loop_nest_sequencer_counter.sv
// Stepping counter that wraps to 0 once the next step would reach the ceiling.
module ceiling_counter #(
    parameter int unsigned Width      = 16,
    parameter bit          HasCeiling = 1'b1,
    parameter int unsigned stepSize   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [Width-1:0] ceiling_i,
    output logic [Width-1:0] value_o,
    output logic             at_last_o,
    output logic             last_value_o
);
    logic [Width-1:0] value_q, value_d;
    logic [Width:0]   sum;

    // One extra bit so value+step never wraps before the ceiling compare.
    assign sum = {1'b0, value_q} + (Width+1)'(stepSize);

    if (HasCeiling) begin : g_ceil
        assign at_last_o = (sum >= {1'b0, ceiling_i});
    end else begin : g_free
        assign at_last_o = sum[Width];
    end

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (tick_i) begin
            value_d = at_last_o ? '0 : sum[Width-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o      = value_q;
    assign last_value_o = tick_i & at_last_o;
endmodule

// File: rtl/loop_nest_sequencer.sv
// Walks an (m, n, k) loop nest, k innermost, emitting one index tuple per beat.
module loop_nest_sequencer
    import loop_nest_sequencer_pkg::*;
#(
    parameter int unsigned Width = DefWidth,
    parameter int unsigned StepM = DefStep,
    parameter int unsigned StepK = DefStep,
    parameter int unsigned StepN = DefStep
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [Width-1:0]       bound_m_i,
    input  logic [Width-1:0]       bound_k_i,
    input  logic [Width-1:0]       bound_n_i,
    output logic                   busy_o,
    output logic                   done_o,
    loop_nest_sequencer_if.master  idx_if
);
    state_e           state_q, state_d;
    logic [Width-1:0] bound_m_q, bound_k_q, bound_n_q;
    logic             start_acc, zero_bound, valid, beat;
    logic             k_last, n_last, m_last;
    logic             k_carry, n_carry, m_carry;
    logic [Width-1:0] m_idx, k_idx, n_idx;

    assign zero_bound = (bound_m_q == '0) || (bound_k_q == '0) || (bound_n_q == '0);
    assign valid      = (state_q == RUN) && !zero_bound;
    assign beat       = valid && idx_if.idx_ready_i;

    ceiling_counter #(.Width(Width), .HasCeiling(1'b1), .stepSize(StepK)) u_k (
        .clk_i, .rst_ni, .clear_i(start_acc), .tick_i(beat), .ceiling_i(bound_k_q),
        .value_o(k_idx), .at_last_o(k_last), .last_value_o(k_carry)
    );

    ceiling_counter #(.Width(Width), .HasCeiling(1'b1), .stepSize(StepN)) u_n (
        .clk_i, .rst_ni, .clear_i(start_acc), .tick_i(k_carry), .ceiling_i(bound_n_q),
        .value_o(n_idx), .at_last_o(n_last), .last_value_o(n_carry)
    );

    // The outermost carry fires exactly on the beat that carries last_o.
    ceiling_counter #(.Width(Width), .HasCeiling(1'b1), .stepSize(StepM)) u_m (
        .clk_i, .rst_ni, .clear_i(start_acc), .tick_i(n_carry), .ceiling_i(bound_m_q),
        .value_o(m_idx), .at_last_o(m_last), .last_value_o(m_carry)
    );

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (zero_bound || m_carry) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bound_m_q <= '0;
            bound_k_q <= '0;
            bound_n_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                bound_m_q <= bound_m_i;
                bound_k_q <= bound_k_i;
                bound_n_q <= bound_n_i;
            end
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    assign idx_if.idx_valid_o = valid;
    assign idx_if.m_idx_o     = m_idx;
    assign idx_if.k_idx_o     = k_idx;
    assign idx_if.n_idx_o     = n_idx;
    assign idx_if.first_k_o   = valid && (k_idx == '0);
    assign idx_if.last_k_o    = valid && k_last;
    assign idx_if.last_o      = valid && k_last && n_last && m_last;
endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Scoreboard bench: driver pushes the expected tuple list per run, monitor pops on each beat.
module tb_loop_nest_sequencer;
    localparam int W  = 16;
    localparam int SM = 4;
    localparam int SK = 4;
    localparam int SN = 4;

    typedef struct {
        int m, n, k;
        bit fk, lk, l;
    } tup_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] bm = '0, bk = '0, bn = '0;
    logic         busy_o, done_o;

    loop_nest_sequencer_if #(.Width(W)) bus ();

    loop_nest_sequencer #(.Width(W), .StepM(SM), .StepK(SK), .StepN(SN)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .bound_m_i(bm), .bound_k_i(bk), .bound_n_i(bn),
        .busy_o(busy_o), .done_o(done_o), .idx_if(bus)
    );

    always #5 clk = ~clk;

    tup_t exp_q[$];
    int   cmp_cnt = 0, err_cnt = 0;
    int   cyc = 0, beats = 0, start_cyc = 0, exp_lat = -1;
    bit   done_pending = 0, ready_rand = 0, prev_stall = 0, prev_done = 0;
    logic [3*W+2:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain nested enumeration of the index ranges.
    task automatic push_expected(input int m, input int k, input int n);
        int ms[$], ns[$], ks[$];
        tup_t t;
        for (int v = 0; v < m; v += SM) ms.push_back(v);
        for (int v = 0; v < n; v += SN) ns.push_back(v);
        for (int v = 0; v < k; v += SK) ks.push_back(v);
        foreach (ms[mi])
            foreach (ns[ni])
                foreach (ks[ki]) begin
                    t.m  = ms[mi];
                    t.n  = ns[ni];
                    t.k  = ks[ki];
                    t.fk = (ki == 0);
                    t.lk = (ki == ks.size() - 1);
                    t.l  = t.lk && (ni == ns.size() - 1) && (mi == ms.size() - 1);
                    exp_q.push_back(t);
                end
    endtask

    always @(posedge clk) begin
        #1;
        bus.idx_ready_i = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            if (prev_stall) begin
                chk("stall_valid", bus.idx_valid_o, 1);
                chk("stall_hold", {bus.m_idx_o, bus.n_idx_o, bus.k_idx_o,
                                   bus.first_k_o, bus.last_k_o, bus.last_o}, snap);
            end
            if (prev_done) chk("done_one_cycle", done_o, 0);
            prev_done = done_o;
            if (!bus.idx_valid_o)
                chk("flags_gated", {bus.first_k_o, bus.last_k_o, bus.last_o}, 0);
            if (bus.idx_valid_o && bus.idx_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", exp_q.size(), 1);
                end else begin
                    tup_t e;
                    e = exp_q.pop_front();
                    chk("m_idx", bus.m_idx_o, e.m);
                    chk("n_idx", bus.n_idx_o, e.n);
                    chk("k_idx", bus.k_idx_o, e.k);
                    chk("first_k", bus.first_k_o, e.fk);
                    chk("last_k", bus.last_k_o, e.lk);
                    chk("last", bus.last_o, e.l);
                end
                beats++;
            end
            prev_stall = bus.idx_valid_o && !bus.idx_ready_i;
            snap = {bus.m_idx_o, bus.n_idx_o, bus.k_idx_o,
                    bus.first_k_o, bus.last_k_o, bus.last_o};
            if (done_o) begin
                chk("done_expected", done_pending, 1);
                chk("done_queue_empty", exp_q.size(), 0);
                if (exp_lat >= 0) chk("done_latency", cyc - start_cyc, exp_lat);
                chk("busy_in_done", busy_o, 1);
                done_pending = 0;
            end
        end else begin
            prev_stall = 0;
            prev_done  = 0;
        end
    end

    task automatic run_case(input int m, input int k, input int n, input bit rnd, input bit poke);
        int nb, t;
        @(posedge clk); #2;
        ready_rand = rnd;
        bm = W'(m); bk = W'(k); bn = W'(n);
        start_i = 1'b1;
        start_cyc = cyc;
        beats = 0;
        push_expected(m, k, n);
        nb = exp_q.size();
        exp_lat = (nb == 0) ? 2 : (rnd ? -1 : nb + 1);
        done_pending = 1;
        @(posedge clk); #2;
        start_i = 1'b0;
        chk("busy_in_run", busy_o, 1);
        bm = W'($urandom_range(0, 40)); bk = W'($urandom_range(0, 40)); bn = W'($urandom_range(0, 40));
        t = 0;
        while (done_pending && t < 2000) begin
            @(posedge clk); #2;
            t++;
            start_i = (poke && beats == 2);
            if (start_i) begin
                bm = W'(12); bk = W'(12); bn = W'(12);
            end
        end
        start_i = 1'b0;
        chk("run_timeout", done_pending, 0);
        chk("beat_count", beats, nb);
        @(posedge clk); #2;
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        bus.idx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", bus.idx_valid_o, 0);
        chk("rst_idx", {bus.m_idx_o, bus.n_idx_o, bus.k_idx_o}, 0);
        rst_ni = 1'b1;

        run_case(8, 8, 4, 0, 0);
        run_case(8, 8, 4, 1, 0);
        run_case(8, 0, 4, 0, 0);
        run_case(4, 6, 4, 0, 0);
        run_case(8, 8, 4, 0, 1);

        // Reset mid-run after the third beat.
        @(posedge clk); #2;
        ready_rand = 0;
        bm = W'(8); bk = W'(8); bn = W'(4);
        start_i = 1'b1;
        beats = 0;
        exp_lat = -1;
        push_expected(8, 8, 4);
        done_pending = 1;
        @(posedge clk); #2;
        start_i = 1'b0;
        for (int t = 0; t < 100 && beats < 3; t++) begin
            @(posedge clk); #2;
        end
        chk("reach_beat3", beats, 3);
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_valid", bus.idx_valid_o, 0);
        chk("midrst_idx", {bus.m_idx_o, bus.n_idx_o, bus.k_idx_o}, 0);
        chk("midrst_flags", {bus.first_k_o, bus.last_k_o, bus.last_o}, 0);
        exp_q.delete();
        done_pending = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        run_case(8, 8, 4, 0, 0);

        for (int i = 0; i < 8; i++)
            run_case($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 13),
                     1'($urandom_range(0, 1)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
